keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives the 4x4 keypad column lines and samples the row lines to find one pressed key.
//  Debounces the press and release, then presents one-hot storedCol/storedRow plus a keyValid strobe.
//  Its outputs feed the keypad digit decoder, which maps {col,row} to a hex digit.
// PARAMETERS
//  SCAN_CYCLES      4096    clocks each column is driven before advancing (>=4)
//  DEBOUNCE_CYCLES  240000  clocks of stable level required to accept a press or release (>=2)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high
//  rowIn      in   4  raw keypad rows, active-low (pull-ups on board), asynchronous to clk
//  colOut     out  4  keypad column drive, active-low; exactly one bit low at all times
//  storedCol  out  4  one-hot column of last accepted key (bit0 = col0)
//  storedRow  out  4  one-hot row of last accepted key (bit0 = row0)
//  keyValid   out  1  one-cycle pulse: new key accepted; stored* updated same cycle
//  keyHeld    out  1  high while the accepted key remains pressed (HELD/RELEASE states)
//  keyReleased out 1  one-cycle pulse on debounced release (only with KEYSCAN_RELEASE_PULSE_EN)
// BEHAVIOUR
//  - rowIn passes a 2-flop synchronizer and is inverted. rowAct = ~sync(rowIn), active-high.
//  - Reset values: state=SCAN, colIdx=0, colOut=4'b1110, storedCol=0, storedRow=0, keyValid=0,
//    keyHeld=0, keyReleased=0, counters=0. Reset asserted mid-operation aborts immediately; no pulse is issued.
//  - States: SCAN, DEBOUNCE, HELD, RELEASE.
//  - SCAN: colOut = ~(1<<colIdx). The dwell counter counts 0..SCAN_CYCLES-1.
//    rowAct is sampled only on the last dwell cycle, so synchronizer latency is never mixed with a column change.
//    - Sample with rowAct==0: colIdx <= colIdx+1, wrapping 3 -> 0.
//    - Sample with rowAct!=0: latch colIdx and the lowest-index active row as candRow, clear the counter, go to DEBOUNCE.
//  - DEBOUNCE: the column is frozen. Each cycle, check (rowAct & candRow) != 0.
//    - Check fails: return to SCAN at the next column.
//    - Check passes for DEBOUNCE_CYCLES consecutive cycles: go to HELD.
//      On the same edge, load storedCol=1<<colIdx and storedRow=candRow; keyValid=1 for that one cycle.
//  - HELD: the column stays frozen and other keys are ignored (one-key lockout).
//    Bit candRow of rowAct deasserted: clear the counter, go to RELEASE.
//  - RELEASE: candRow reasserted before DEBOUNCE_CYCLES: back to HELD, with no new keyValid.
//    Released for DEBOUNCE_CYCLES: go to SCAN at the next column, and keyReleased pulses if enabled.
//  - storedCol/storedRow hold their value until the next keyValid. They are never cleared on release.
//  - Two keys in the same column pressed together: lowest row wins.
//    Keys in different columns: the first column scanned wins.
//  - Counter width is $clog2(max(SCAN_CYCLES,DEBOUNCE_CYCLES)). Counters saturate and never wrap within a state.
//  - Press latency, pin to keyValid: <= 4*SCAN_CYCLES + 2 + DEBOUNCE_CYCLES + 1 clocks.
// CONFIGURATION
//  KEYSCAN_RELEASE_PULSE_EN defined:
//    keyReleased port exists; it pulses 1 cycle on the RELEASE->SCAN transition.
//  KEYSCAN_RELEASE_PULSE_EN undefined:
//    keyReleased port is absent and no release logic is emitted.
//    All other behaviour is identical.
// STRUCTURE
//  - keypad_pkg:
//    - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t
//    - NUM_COLS=4, NUM_ROWS=4
//    - function onehot_lowest(logic [3:0]) returning the lowest set bit.
//  - Sub-module keypad_row_sync: 4-bit 2-flop synchronizer, clk/reset, reset value 4'hF (idle high).
//  - Main FSM, counters and output registers live in keypad_scanner.
// TESTING  (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8; bench models keypad: rowIn[r]=0 iff key(colOut-low,r) pressed)
//  1 Reset, no keys:
//    colOut cycles 1110->1101->1011->0111->1110 every 4 clocks.
//    keyValid never asserts; stored*=0.
//  2 Hold key (col2,row1) stable:
//    exactly one keyValid with storedCol=0100, storedRow=0010; keyHeld=1.
//    colOut stays 1011 while held.
//  3 Key (col0,row3) pressed for 3 clocks then bounces off:
//    no keyValid; scanning resumes at col1.
//  4 Accept (col3,row0), release for 5 clocks, re-press, release for 10 clocks:
//    single keyValid only; keyReleased pulses once (macro on).
//    stored* stays 1000/0001 after release.
//  5 Keys (col1,row2) and (col1,row0) both pressed:
//    storedCol=0010, storedRow=0001.
//    A later press of (col3,row3) while held is ignored.
//  6 Assert reset during DEBOUNCE and during HELD:
//    outputs return to reset values asynchronously; no keyValid/keyReleased emitted.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and helpers for the 4x4 keypad scanner.
//   scan_state_t   : scanner FSM states
//   NUM_COLS/ROWS  : keypad geometry
//   onehot_lowest  : isolates the lowest set bit of a row vector
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  // Lowest set bit wins when several rows of one column are active.
  function automatic logic [NUM_ROWS-1:0] onehot_lowest(input logic [NUM_ROWS-1:0] v);
    return v & (~v + NUM_ROWS'(1));
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the raw keypad rows.
//   clk   in  system clock
//   reset in  asynchronous, active-high
//   d     in  [NUM_ROWS] raw rows (active-low, async to clk)
//   q     out [NUM_ROWS] synchronized rows, reset to all-ones (idle)
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] d,
  output logic [NUM_ROWS-1:0] q
);

  logic [NUM_ROWS-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces press and release of a single key
// and reports the accepted key as one-hot column/row.
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   rowIn        in   [4] raw rows, active-low
//   colOut       out  [4] column drive, active-low, exactly one bit low
//   storedCol    out  [4] one-hot column of last accepted key
//   storedRow    out  [4] one-hot row of last accepted key
//   keyValid     out  one-cycle pulse when a key is accepted
//   keyHeld      out  high while the accepted key is still pressed
//   keyReleased  out  one-cycle pulse on debounced release
//                     (present only when KEYSCAN_RELEASE_PULSE_EN is defined)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rowIn,
  output logic [NUM_COLS-1:0] colOut,
  output logic [NUM_COLS-1:0] storedCol,
  output logic [NUM_ROWS-1:0] storedRow,
  output logic                keyValid,
  output logic                keyHeld
`ifdef KEYSCAN_RELEASE_PULSE_EN
  ,
  output logic                keyReleased
`endif
);

  localparam int unsigned MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                         : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
  localparam int unsigned COL_W      = $clog2(NUM_COLS);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  scan_state_t         state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NUM_ROWS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_COLS-1:0] col_out_d, stored_col_d;
  logic [NUM_ROWS-1:0] stored_row_d;
  logic                key_valid_d, key_held_d;
`ifdef KEYSCAN_RELEASE_PULSE_EN
  logic                key_released_d;
`endif

  logic [NUM_ROWS-1:0] row_sync, row_act;
  logic                cand_hit;

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rowIn),
    .q     (row_sync)
  );

  assign row_act  = ~row_sync;
  assign cand_hit = |(row_act & cand_q);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      colOut      <= ~NUM_COLS'(1);
      storedCol   <= '0;
      storedRow   <= '0;
      keyValid    <= 1'b0;
      keyHeld     <= 1'b0;
`ifdef KEYSCAN_RELEASE_PULSE_EN
      keyReleased <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      colOut      <= col_out_d;
      storedCol   <= stored_col_d;
      storedRow   <= stored_row_d;
      keyValid    <= key_valid_d;
      keyHeld     <= key_held_d;
`ifdef KEYSCAN_RELEASE_PULSE_EN
      keyReleased <= key_released_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    cand_d         = cand_q;
    cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    stored_col_d   = storedCol;
    stored_row_d   = storedRow;
    key_valid_d    = 1'b0;
`ifdef KEYSCAN_RELEASE_PULSE_EN
    key_released_d = 1'b0;
`endif

    unique case (state_q)
      SCAN: begin
        // Rows are only looked at on the last dwell cycle, after the
        // synchronizer has settled on the current column.
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_act == '0) begin
            col_d = col_q + COL_W'(1);
          end else begin
            cand_d  = onehot_lowest(row_act);
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (!cand_hit) begin
          state_d = SCAN;
          col_d   = col_q + COL_W'(1);
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d      = HELD;
          cnt_d        = '0;
          stored_col_d = NUM_COLS'(1) << col_q;
          stored_row_d = cand_q;
          key_valid_d  = 1'b1;
        end
      end
      HELD: begin
        // Other rows are ignored: only the accepted key is watched.
        cnt_d = '0;
        if (!cand_hit) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cand_hit) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + COL_W'(1);
          cnt_d   = '0;
`ifdef KEYSCAN_RELEASE_PULSE_EN
          key_released_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    col_out_d  = ~(NUM_COLS'(1) << col_d);
    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with SCAN_CYCLES=4,
// DEBOUNCE_CYCLES=8. A behavioural keypad pulls a row low when its key is pressed
// in the currently driven column. Expected accepted keys are queued on stimulus
// and compared when keyValid pulses. Define KEYSCAN_RELEASE_PULSE_EN to cover keyReleased.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rowIn;
  logic [3:0] colOut, storedCol, storedRow;
  logic       keyValid, keyHeld;
`ifdef KEYSCAN_RELEASE_PULSE_EN
  logic       keyReleased;
`endif

  logic [15:0] keys = '0;   // bit c*4+r : key (col c, row r) pressed

  int n_checks = 0;
  int n_pass   = 0;
  int kv_seen  = 0;

  logic [7:0] exp_q[$];     // {storedCol, storedRow}
`ifdef KEYSCAN_RELEASE_PULSE_EN
  logic [3:0] rel_q[$];     // storedCol expected at release pulse
`endif

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rowIn       (rowIn),
    .colOut      (colOut),
    .storedCol   (storedCol),
    .storedRow   (storedRow),
    .keyValid    (keyValid),
    .keyHeld     (keyHeld)
`ifdef KEYSCAN_RELEASE_PULSE_EN
    ,
    .keyReleased (keyReleased)
`endif
  );

  // Keypad matrix model.
  always_comb begin
    rowIn = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!colOut[c] && keys[c*4+r]) rowIn[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard consumers.
  always @(negedge clk) begin
    if (!reset && keyValid) begin
      kv_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_keyValid", 32'(1), 32'(0));
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("storedCol", 32'(storedCol), 32'(e[7:4]));
        check("storedRow", 32'(storedRow), 32'(e[3:0]));
      end
    end
`ifdef KEYSCAN_RELEASE_PULSE_EN
    if (!reset && keyReleased) begin
      if (rel_q.size() == 0) begin
        check("spurious_keyReleased", 32'(1), 32'(0));
      end else begin
        logic [3:0] rc;
        rc = rel_q.pop_front();
        check("release_storedCol", 32'(storedCol), 32'(rc));
      end
    end
`endif
  end

  task automatic wait_valid(input string tag, input int max_cyc);
    int  start;
    logic seen;
    start = kv_seen;
    seen  = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk); #1;
      if (kv_seen != start) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  task automatic wait_release(input string tag, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk); #1;
      if (!keyHeld) done = 1'b1;
    end
    check(tag, 32'(done), 32'(1));
  endtask

  // Returns at the negedge right after colOut switched to the given column.
  task automatic align_col(input string tag, input logic [3:0] target);
    logic [3:0] prev;
    logic found;
    prev  = colOut;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (colOut == target && prev != target) found = 1'b1;
      prev = colOut;
    end
    check(tag, 32'(found), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_colOut"},    32'(colOut),    32'(4'b1110));
    check({tag, "_storedCol"}, 32'(storedCol), 32'(0));
    check({tag, "_storedRow"}, 32'(storedRow), 32'(0));
    check({tag, "_keyValid"},  32'(keyValid),  32'(0));
    check({tag, "_keyHeld"},   32'(keyHeld),   32'(0));
`ifdef KEYSCAN_RELEASE_PULSE_EN
    check({tag, "_keyReleased"}, 32'(keyReleased), 32'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] expc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("t1_reset");
    reset = 1'b0;

    // 1: idle scan rotates every 4 clocks.
    for (int k = 0; k < 8; k++) begin
      expc = ~(4'b0001 << (k % 4));
      check("t1_colOut", 32'(colOut), 32'(expc));
      repeat (4) @(negedge clk);
    end
    check("t1_storedCol", 32'(storedCol), 32'(0));
    check("t1_keyHeld", 32'(keyHeld), 32'(0));

    // 2: stable key (col2,row1).
    exp_q.push_back({4'b0100, 4'b0010});
    keys[2*4+1] = 1'b1;
    wait_valid("t2_accept", 60);
    check("t2_keyHeld", 32'(keyHeld), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_colOut_frozen", 32'(colOut), 32'(4'b1011));
    end
`ifdef KEYSCAN_RELEASE_PULSE_EN
    rel_q.push_back(4'b0100);
`endif
    keys = '0;
    wait_release("t2_release", 40);

    // 3: (col0,row3) pressed 3 clocks then gone: debounce aborts, next column.
    align_col("t3_align", 4'b1110);
    keys[0*4+3] = 1'b1;
    repeat (3) @(negedge clk);
    keys = '0;
    repeat (3) @(negedge clk);
    check("t3_resume_col1", 32'(colOut), 32'(4'b1101));
    repeat (20) @(negedge clk);
    check("t3_no_held", 32'(keyHeld), 32'(0));

    // 4: short release glitch is absorbed; one keyValid, one release.
    exp_q.push_back({4'b1000, 4'b0001});
    keys[3*4+0] = 1'b1;
    wait_valid("t4_accept", 60);
    repeat (4) @(negedge clk);
    keys = '0;
    repeat (5) @(negedge clk);
    check("t4_held_during_glitch", 32'(keyHeld), 32'(1));
    keys[3*4+0] = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_held_after_repress", 32'(keyHeld), 32'(1));
`ifdef KEYSCAN_RELEASE_PULSE_EN
    rel_q.push_back(4'b1000);
`endif
    keys = '0;
    wait_release("t4_release", 40);
    check("t4_next_col", 32'(colOut), 32'(4'b1110));
    repeat (3) @(negedge clk);
    check("t4_storedCol_kept", 32'(storedCol), 32'(4'b1000));
    check("t4_storedRow_kept", 32'(storedRow), 32'(4'b0001));

    // 5: two rows in col1 -> lowest row; later key in col3 locked out.
    exp_q.push_back({4'b0010, 4'b0001});
    keys[1*4+2] = 1'b1;
    keys[1*4+0] = 1'b1;
    wait_valid("t5_accept", 60);
    keys[3*4+3] = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_lockout_colOut", 32'(colOut), 32'(4'b1101));
    check("t5_lockout_held", 32'(keyHeld), 32'(1));
    check("t5_lockout_storedRow", 32'(storedRow), 32'(4'b0001));
`ifdef KEYSCAN_RELEASE_PULSE_EN
    rel_q.push_back(4'b0010);
`endif
    keys = '0;
    wait_release("t5_release", 40);

    // 6a: reset while debouncing (col0,row0).
    align_col("t6_align", 4'b1110);
    keys[0] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_debounce_reset");
    keys = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_after_debounce_reset_held", 32'(keyHeld), 32'(0));

    // 6b: reset while held.
    exp_q.push_back({4'b0100, 4'b1000});
    keys[2*4+3] = 1'b1;
    wait_valid("t6_accept", 60);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_held_reset");
    keys = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_stored_after_reset", 32'(storedCol), 32'(0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
`ifdef KEYSCAN_RELEASE_PULSE_EN
    check("release_queue_empty", 32'(rel_q.size()), 32'(0));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
